// File: rtl/pg_pkg.sv
// rtl/pg_pkg.sv - shared types and constants for the power-gating controller
package pg_pkg;

    typedef enum logic [2:0] {
        ON,
        ISO,
        OFF,
        WAKE,
        DEISO
    } pg_state_t;

    localparam int DOM_SHIFT = 0;
    localparam int DOM_MEM   = 1;

    localparam int IDLE_W = 8;
    localparam int WAKE_W = 4;
    localparam int STAT_W = 16;

endpackage

// File: rtl/pg_ctrl_if.sv
// rtl/pg_ctrl_if.sv - request/status bundle between the pipeline and pg_ctrl
interface pg_ctrl_if
    import pg_pkg::*;
#(
    parameter int NUM_DOM = 2
);
    logic                      pg_enable;
    logic [NUM_DOM-1:0]        req;
    logic [NUM_DOM-1:0]        sleep;
    logic [NUM_DOM-1:0]        iso;
    logic [NUM_DOM-1:0]        dom_on;
    logic                      stall;
    logic [NUM_DOM*STAT_W-1:0] off_cycles;

    modport master (
        output pg_enable, req,
        input  sleep, iso, dom_on, stall, off_cycles
    );

    modport slave (
        input  pg_enable, req,
        output sleep, iso, dom_on, stall, off_cycles
    );
endinterface

// File: rtl/pg_domain_fsm.sv
// rtl/pg_domain_fsm.sv - per-domain sleep/isolation sequencer; PG_STATS_EN adds an OFF-cycle counter
module pg_domain_fsm
    import pg_pkg::*;
#(
    parameter int IDLE_CYCLES = 16,
    parameter int WAKE_CYCLES = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pg_enable,
    input  logic              req,
    output logic              sleep,
    output logic              iso,
    output logic              dom_on,
    output logic [STAT_W-1:0] off_cycles
);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_CYCLES - 1);
    localparam logic [WAKE_W-1:0] WAKE_LOAD = WAKE_W'(WAKE_CYCLES - 1);

    pg_state_t         state_q, state_d;
    logic [IDLE_W-1:0] idle_q, idle_d;
    logic [WAKE_W-1:0] wake_q, wake_d;
    logic              sleep_q, sleep_d;
    logic              iso_q, iso_d;
    logic              on_q, on_d;
    logic              gate_ok;

    assign gate_ok = pg_enable & ~req;

    always_comb begin
        state_d = state_q;
        idle_d  = '0;
        wake_d  = wake_q;
        unique case (state_q)
            ON: begin
                if (gate_ok) begin
                    idle_d = (idle_q == IDLE_LAST) ? idle_q : idle_q + 1'b1;
                    if (idle_q == IDLE_LAST) state_d = ISO;
                end
            end
            ISO:   state_d = gate_ok ? OFF : ON;
            OFF: begin
                if (req || !pg_enable) begin
                    state_d = WAKE;
                    wake_d  = WAKE_LOAD;
                end
            end
            // Rail settling time is fixed; a request cannot shorten it.
            WAKE: begin
                if (wake_q == '0) state_d = DEISO;
                else              wake_d  = wake_q - 1'b1;
            end
            DEISO:   state_d = ON;
            default: state_d = ON;
        endcase
        sleep_d = (state_d == OFF);
        iso_d   = (state_d == ISO) || (state_d == OFF) || (state_d == WAKE);
        on_d    = (state_d == ON);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ON;
            idle_q  <= '0;
            wake_q  <= '0;
            sleep_q <= 1'b0;
            iso_q   <= 1'b0;
            on_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            idle_q  <= idle_d;
            wake_q  <= wake_d;
            sleep_q <= sleep_d;
            iso_q   <= iso_d;
            on_q    <= on_d;
        end
    end

    assign sleep  = sleep_q;
    assign iso    = iso_q;
    assign dom_on = on_q;

`ifdef PG_STATS_EN
    logic [STAT_W-1:0] stat_q, stat_d;

    always_comb begin
        stat_d = stat_q;
        if (state_q == OFF && stat_q != '1) stat_d = stat_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) stat_q <= '0;
        else       stat_q <= stat_d;
    end

    assign off_cycles = stat_q;
`else
    assign off_cycles = '0;
`endif

endmodule

// File: rtl/pg_ctrl.sv
// rtl/pg_ctrl.sv - power-gating controller top: one sequencer per domain plus stall reduction
module pg_ctrl
    import pg_pkg::*;
#(
    parameter int IDLE_CYCLES = 16,
    parameter int WAKE_CYCLES = 4,
    parameter int NUM_DOM     = 2
) (
    input  logic      clk,
    input  logic      reset,
    pg_ctrl_if.slave  bus
);
    logic [NUM_DOM-1:0]        sleep_vec;
    logic [NUM_DOM-1:0]        iso_vec;
    logic [NUM_DOM-1:0]        on_vec;
    logic [NUM_DOM*STAT_W-1:0] stat_vec;

    for (genvar i = 0; i < NUM_DOM; i++) begin : g_dom
        pg_domain_fsm #(
            .IDLE_CYCLES (IDLE_CYCLES),
            .WAKE_CYCLES (WAKE_CYCLES)
        ) u_fsm (
            .clk        (clk),
            .reset      (reset),
            .pg_enable  (bus.pg_enable),
            .req        (bus.req[i]),
            .sleep      (sleep_vec[i]),
            .iso        (iso_vec[i]),
            .dom_on     (on_vec[i]),
            .off_cycles (stat_vec[i*STAT_W +: STAT_W])
        );
    end

    assign bus.sleep      = sleep_vec;
    assign bus.iso        = iso_vec;
    assign bus.dom_on     = on_vec;
    assign bus.off_cycles = stat_vec;
    // Combinational so a request to an ON domain never stalls.
    assign bus.stall      = |(bus.req & ~on_vec);

endmodule

// File: tb/tb_pg_ctrl.sv
// tb/tb_pg_ctrl.sv - scoreboard bench for pg_ctrl against a timestamp-based reference model
module tb_pg_ctrl;
    import pg_pkg::*;

    localparam int IDLE = 16;
    localparam int WAKE = 4;
    localparam int ND   = 2;
    localparam logic [ND-1:0] R_SHIFT = ND'(1) << DOM_SHIFT;
    localparam logic [ND-1:0] R_MEM   = ND'(1) << DOM_MEM;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    pg_ctrl_if #(.NUM_DOM(ND)) bus ();

    pg_ctrl #(
        .IDLE_CYCLES (IDLE),
        .WAKE_CYCLES (WAKE),
        .NUM_DOM     (ND)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [ND-1:0]        sleep;
        logic [ND-1:0]        iso;
        logic [ND-1:0]        on;
        logic                 stall;
        logic [ND*STAT_W-1:0] offc;
        int                   cyc;
    } exp_t;

    exp_t sbq[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model: RUN / CLAMP / DARK / RISING, with rising timed from its start cycle.
    localparam int P_RUN = 0, P_CLAMP = 1, P_DARK = 2, P_RISE = 3;
    int phase    [ND];
    int idle_run [ND];
    int rise_at  [ND];
    int dark_cnt [ND];
    int cyc = 0;
    logic          last_stall = 1'b0;
    logic [ND-1:0] last_req   = '0;

    task automatic chk(input string nm, input int c, input logic [63:0] act, input logic [63:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", nm, c, act, expv);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < ND; d++) begin
            phase[d] = P_RUN; idle_run[d] = 0; rise_at[d] = 0; dark_cnt[d] = 0;
        end
    endtask

    task automatic model_emit(input logic [ND-1:0] rq);
        exp_t e;
        e.offc = '0;
        for (int d = 0; d < ND; d++) begin
            e.sleep[d] = (phase[d] == P_DARK);
            e.on[d]    = (phase[d] == P_RUN);
            e.iso[d]   = (phase[d] == P_CLAMP) || (phase[d] == P_DARK) ||
                         (phase[d] == P_RISE && (cyc - rise_at[d]) < WAKE);
`ifdef PG_STATS_EN
            e.offc[d*STAT_W +: STAT_W] = STAT_W'(dark_cnt[d]);
`endif
        end
        e.stall = |(rq & ~e.on);
        e.cyc   = cyc;
        last_stall = e.stall;
        sbq.push_back(e);
    endtask

    task automatic model_step(input logic rst, input logic en, input logic [ND-1:0] rq);
        for (int d = 0; d < ND; d++) begin
            if (rst) begin
                phase[d] = P_RUN; idle_run[d] = 0; dark_cnt[d] = 0;
            end else begin
                if (phase[d] == P_DARK && dark_cnt[d] < 65535) dark_cnt[d]++;
                case (phase[d])
                    P_RUN: begin
                        if (!en || rq[d]) idle_run[d] = 0;
                        else if (idle_run[d] >= IDLE - 1) begin phase[d] = P_CLAMP; idle_run[d] = 0; end
                        else idle_run[d]++;
                    end
                    P_CLAMP: begin
                        phase[d] = (en && !rq[d]) ? P_DARK : P_RUN;
                        idle_run[d] = 0;
                    end
                    P_DARK: if (rq[d] || !en) begin phase[d] = P_RISE; rise_at[d] = cyc + 1; end
                    default: if (cyc - rise_at[d] == WAKE) begin phase[d] = P_RUN; idle_run[d] = 0; end
                endcase
            end
        end
        cyc++;
    endtask

    task automatic drive(input logic rst, input logic en, input logic [ND-1:0] rq);
        @(posedge clk);
        #1;
        reset         = rst;
        bus.pg_enable = en;
        bus.req       = rq;
        last_req      = rq;
        model_emit(rq);
        model_step(rst, en, rq);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                chk("sleep",      e.cyc, 64'(bus.sleep),      64'(e.sleep));
                chk("iso",        e.cyc, 64'(bus.iso),        64'(e.iso));
                chk("dom_on",     e.cyc, 64'(bus.dom_on),     64'(e.on));
                chk("stall",      e.cyc, 64'(bus.stall),      64'(e.stall));
                chk("off_cycles", e.cyc, 64'(bus.off_cycles), 64'(e.offc));
            end
        end
    end

    initial begin : stimulus
        int cnt;
        logic [ND-1:0] rq;
        logic en;
        reset = 1'b1; bus.pg_enable = 1'b1; bus.req = '0;
        repeat (2) @(posedge clk);
        model_reset();

        // Power-down from reset, then wake domain 0 on demand.
        repeat (20) drive(0, 1, '0);
        cnt = 0;
        for (int k = 0; k < 20; k++) begin
            drive(0, 1, R_SHIFT);
            @(negedge clk);
            if (bus.stall === 1'b1) cnt++;
            else break;
        end
        chk("wake_stall_len", cyc, 64'(cnt), 64'(WAKE + 2));
        repeat (3) drive(0, 1, R_SHIFT);

        // Domain 1 kept busy by periodic requests while domain 0 gates.
        drive(1, 1, '0);
        for (int k = 0; k < 60; k++) drive(0, 1, (k % 10 == 0) ? R_MEM : '0);

        // Request lands exactly in the ISO cycle.
        drive(1, 1, '0);
        repeat (IDLE) drive(0, 1, '0);
        cnt = 0;
        for (int k = 0; k < 4; k++) begin
            drive(0, 1, (k == 0) ? R_SHIFT : '0);
            @(negedge clk);
            if (bus.stall === 1'b1) cnt++;
        end
        chk("iso_stall_len", cyc, 64'(cnt), 64'(1));

        // Both OFF, then global disable wakes both and holds them ON.
        repeat (25) drive(0, 1, '0);
        repeat (40) drive(0, 0, '0);

        // Long OFF stretch, wake both, reset in the middle of WAKE.
        repeat (IDLE + 2 + 50) drive(0, 1, '0);
        drive(0, 1, '1);
        drive(0, 1, '1);
        drive(1, 1, '1);
        repeat (5) drive(0, 1, '0);

        // Randomized traffic; requests are held while stalled.
        en = 1'b1;
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 59) == 0) en = ~en;
            if (last_stall) rq = last_req;
            else for (int d = 0; d < ND; d++) rq[d] = ($urandom_range(0, 29) == 0);
            drive($urandom_range(0, 199) == 0, en, rq);
        end
        drive(0, 1, '0);

        cnt = 0;
        while (sbq.size() > 0 && cnt < 5) begin
            @(negedge clk);
            #1;
            cnt++;
        end
        chk("scoreboard_drained", cyc, 64'(sbq.size()), 64'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
